burst_page_responder: RTL
=========================

BURST_PAGE_RESPONDER -- requirements
Module: burst_page_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, word width.
REQ-002 SHALL have parameter ADDR_W, default 12, page-address width of f_addr.
REQ-003 SHALL have parameter PAGE_WORDS, default 512, words per full-page burst (power of two).
REQ-004 SHALL have parameter NUM_PAGES, default 4, pages of on-chip backing store (power of two); page index = f_addr mod NUM_PAGES.
REQ-005 SHALL have parameters LAT, default 3, command-to-first-data cycles (>=2), and TRP, default 2, post-burst recovery cycles (>=1).
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have ports rw  input  1  1=read, 0=write; rw_en  input  1  command strobe.
REQ-009 SHALL have port f_addr  input  ADDR_W  page address; no column address, bursts always cover words 0..PAGE_WORDS-1.
REQ-010 SHALL have ports f2s_data  input  DATA_W  write word; s2f_data  output  DATA_W  read word.
REQ-011 SHALL have ports f2s_data_valid  output  1  write-word capture strobe; s2f_data_valid  output  1  read-word valid.
REQ-012 SHALL have ports ready  output  1  command accepted this cycle if rw_en=1; cmd_dropped  output  1  one-cycle pulse for rw_en while ready=0.

Function
REQ-013 SHALL implement FSM states IDLE, LATENCY, BURST, RECOVER (plus REFRESH under REQ-024); ready=1 only in IDLE.
REQ-014 SHALL accept a command on the edge where ready=1 and rw_en=1, latching rw and page index; ready drops the following cycle.
REQ-015 SHALL stay in LATENCY for LAT-1 cycles, then BURST for exactly PAGE_WORDS cycles, then RECOVER for TRP cycles, then IDLE.
REQ-016 SHALL, on write, assert f2s_data_valid during BURST only; word k captured from f2s_data on the k-th edge with f2s_data_valid=1, stored at page*PAGE_WORDS+k.
REQ-017 SHALL, on read, drive s2f_data registered and aligned with s2f_data_valid, k-th valid cycle carrying stored word k; BRAM read latency hidden by issuing addresses one cycle early.
REQ-018 SHALL present first valid cycle exactly LAT cycles after the acceptance edge; ready re-asserts exactly LAT+PAGE_WORDS+TRP cycles after it.
REQ-019 SHALL ignore rw_en when ready=0 (no queuing), pulsing cmd_dropped for each such cycle.
REQ-020 SHALL wrap burst word counter at PAGE_WORDS-1 with no carry into page index; f_addr bits above log2(NUM_PAGES) ignored.
REQ-021 SHALL never assert f2s_data_valid and s2f_data_valid in the same cycle.
REQ-022 SHALL hold s2f_data at its last value outside valid cycles.

Reset
REQ-023 SHALL, on rst_n=0 at any time including mid-burst: state IDLE, ready=0 while asserted and 1 from first cycle after release, all valids=0, cmd_dropped=0, s2f_data=0, counters=0; backing memory contents not cleared.

Configuration
REQ-024 SHALL, with BURST_RESPONDER_REFRESH_EN defined, run a refresh-interval counter (parameter REF_INTERVAL, default 1100 cycles); on expiry a pending flag is set, serviced from IDLE before any command by REFRESH for TRFC (default 9) cycles with ready=0; pending flag never interrupts a burst.
REQ-025 SHALL, without BURST_RESPONDER_REFRESH_EN, omit REFRESH state, counter and parameters; ready timing per REQ-018 only.

Structure
REQ-026 SHALL place FSM state encodings and default LAT/TRP/PAGE_WORDS constants in shared package sdram_burst_pkg, reused by the initiator side.
REQ-027 SHALL instantiate one sub-module, page_ram (simple dual-port, 1-cycle registered read, NUM_PAGES*PAGE_WORDS x DATA_W); FSM and counters remain in the top module.

Verification (bench params: PAGE_WORDS=8, NUM_PAGES=4, LAT=3, TRP=2)
REQ-028 SHALL cover: write page 1 with f2s_data=0x0100+k -> f2s_data_valid high cycles 3..10 after accept, ready back at cycle 13.
REQ-029 SHALL cover: read page 1 after that write -> s2f_data_valid 8 cycles, words 0x0100..0x0107 in order, first at cycle 3.
REQ-030 SHALL cover: f_addr=5 write then f_addr=1 read -> returns the f_addr=5 data (alias mod 4).
REQ-031 SHALL cover: rw_en held high through a burst -> cmd_dropped pulses every non-ready cycle, next command accepted on first ready cycle.
REQ-032 SHALL cover: rst_n low at burst word 4 -> valids 0 immediately, ready=1 first cycle after release, prior page data intact on re-read.
REQ-033 SHALL cover (macro defined, REF_INTERVAL=20, TRFC=9): refresh pending during burst -> burst completes all 8 words, then ready low 9 extra cycles before accept.

Source files
------------

// File: rtl/sdram_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_burst_pkg
// Description : State encodings and timing defaults shared by the burst
//               responder and initiator sides. BURST_RESPONDER_REFRESH_EN adds
//               the REFRESH state and the refresh timing defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_burst_pkg;

    localparam int C_LAT_DEF        = 3;
    localparam int C_TRP_DEF        = 2;
    localparam int C_PAGE_WORDS_DEF = 512;
`ifdef BURST_RESPONDER_REFRESH_EN
    localparam int C_REF_INTERVAL_DEF = 1100;
    localparam int C_TRFC_DEF         = 9;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LATENCY = 3'd1,
        ST_BURST   = 3'd2,
        ST_RECOVER = 3'd3
`ifdef BURST_RESPONDER_REFRESH_EN
        ,
        ST_REFRESH = 3'd4
`endif
    } burst_state_e;

    // Never returns 0 so degenerate parameters still give a legal vector width.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/page_ram.sv
`default_nettype none
// ============================================================================
// Module      : page_ram
// Description : Simple dual-port backing store, one write port and one read
//               port with a single registered read stage.
// Revision    : 1.0 - initial release
// ============================================================================
module page_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2048,
    parameter int AW     = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // The array keeps its contents through reset; only the output stage clears.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/burst_page_responder.sv
`default_nettype none
// ============================================================================
// Module      : burst_page_responder
// Description : Full-page burst target backed by on-chip RAM. Optional refresh
//               scheduling is built when BURST_RESPONDER_REFRESH_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_page_responder
    import sdram_burst_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 12,
    parameter int PAGE_WORDS = C_PAGE_WORDS_DEF,
    parameter int NUM_PAGES  = 4,
    parameter int LAT        = C_LAT_DEF,
    parameter int TRP        = C_TRP_DEF
`ifdef BURST_RESPONDER_REFRESH_EN
    ,
    parameter int REF_INTERVAL = C_REF_INTERVAL_DEF,
    parameter int TRFC         = C_TRFC_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rw,
    input  logic              rw_en,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic [DATA_W-1:0] f2s_data,
    output logic [DATA_W-1:0] s2f_data,
    output logic              f2s_data_valid,
    output logic              s2f_data_valid,
    output logic              ready,
    output logic              cmd_dropped
);

    localparam int WORD_W = clog2_min1(PAGE_WORDS);
    localparam int PG_W   = clog2_min1(NUM_PAGES);
    localparam int MEM_AW = PG_W + WORD_W;
`ifdef BURST_RESPONDER_REFRESH_EN
    localparam int CNT_SPAN = PAGE_WORDS + LAT + TRP + TRFC;
    localparam int REF_W    = clog2_min1(REF_INTERVAL);
`else
    localparam int CNT_SPAN = PAGE_WORDS + LAT + TRP;
`endif
    localparam int CNT_W = clog2_min1(CNT_SPAN) + 1;

    localparam logic [CNT_W-1:0] C_LAT_LAST   = CNT_W'(LAT - 2);
    localparam logic [CNT_W-1:0] C_BURST_LAST = CNT_W'(PAGE_WORDS - 1);
    localparam logic [CNT_W-1:0] C_TRP_LAST   = CNT_W'(TRP - 1);
`ifdef BURST_RESPONDER_REFRESH_EN
    localparam logic [CNT_W-1:0] C_TRFC_LAST  = CNT_W'(TRFC - 1);
    localparam logic [REF_W-1:0] C_REF_LAST   = REF_W'(REF_INTERVAL - 1);
`endif

    burst_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rw_q, rw_d;
    logic [PG_W-1:0]  page_q, page_d;

    logic [PG_W-1:0]   w_page_sel;
    logic              w_ready;
    logic              w_ref_block;
    logic              w_rd_en;
    logic [WORD_W-1:0] w_rd_word;
    logic [MEM_AW-1:0] w_rd_addr;
    logic [MEM_AW-1:0] w_wr_addr;
    logic              w_wr_en;

    // Only the low page-index bits of f_addr select storage; the rest alias.
    generate
        if (NUM_PAGES > 1) begin : g_page_sel
            assign w_page_sel = f_addr[PG_W-1:0];
            if (ADDR_W > PG_W) begin : g_addr_upper
                logic w_unused_addr_hi;
                assign w_unused_addr_hi = ^f_addr[ADDR_W-1:PG_W];
            end
        end else begin : g_page_single
            logic w_unused_addr_all;
            assign w_page_sel        = '0;
            assign w_unused_addr_all = ^f_addr;
        end
    endgenerate

`ifdef BURST_RESPONDER_REFRESH_EN
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic             ref_pend_q, ref_pend_d;
    logic             w_ref_expire;

    assign w_ref_expire = (ref_cnt_q == C_REF_LAST);
    assign w_ref_block  = ref_pend_q;

    // Pending is consumed on REFRESH entry, even if the interval expires that same cycle.
    always_comb begin
        ref_cnt_d  = w_ref_expire ? '0 : ref_cnt_q + REF_W'(1);
        ref_pend_d = ref_pend_q | w_ref_expire;
        if ((state_d == ST_REFRESH) && (state_q != ST_REFRESH)) begin
            ref_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
        end else begin
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
        end
    end
`else
    assign w_ref_block = 1'b0;
`endif

    assign w_ready = rst_n && (state_q == ST_IDLE) && !w_ref_block;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        page_d  = page_q;
        case (state_q)
            ST_IDLE: begin
                if (w_ready && rw_en) begin
                    state_d = ST_LATENCY;
                    cnt_d   = '0;
                    rw_d    = rw;
                    page_d  = w_page_sel;
                end
`ifdef BURST_RESPONDER_REFRESH_EN
                else if (ref_pend_q) begin
                    state_d = ST_REFRESH;
                    cnt_d   = '0;
                end
`endif
            end
            ST_LATENCY: begin
                if (cnt_q == C_LAT_LAST) begin
                    state_d = ST_BURST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BURST: begin
                if (cnt_q == C_BURST_LAST) begin
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RECOVER: begin
                if (cnt_q == C_TRP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
`ifdef BURST_RESPONDER_REFRESH_EN
                    // Go straight to refresh so no idle cycle is spent on it.
                    if (ref_pend_q || w_ref_expire) begin
                        state_d = ST_REFRESH;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef BURST_RESPONDER_REFRESH_EN
            ST_REFRESH: begin
                if (cnt_q == C_TRFC_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            page_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            page_q  <= page_d;
        end
    end

    // Read addresses lead the data by one cycle to cover the RAM output register.
    assign w_rd_en   = rw_q && (((state_q == ST_LATENCY) && (cnt_q == C_LAT_LAST)) ||
                                ((state_q == ST_BURST) && (cnt_q != C_BURST_LAST)));
    assign w_rd_word = (state_q == ST_BURST) ? cnt_q[WORD_W-1:0] + WORD_W'(1) : '0;
    assign w_rd_addr = {page_q, w_rd_word};
    assign w_wr_en   = (state_q == ST_BURST) && !rw_q;
    assign w_wr_addr = {page_q, cnt_q[WORD_W-1:0]};

    page_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (NUM_PAGES * PAGE_WORDS),
        .AW     (MEM_AW)
    ) u_page_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (w_wr_en),
        .wr_addr_i (w_wr_addr),
        .wr_data_i (f2s_data),
        .rd_en_i   (w_rd_en),
        .rd_addr_i (w_rd_addr),
        .rd_data_o (s2f_data)
    );

    assign ready          = w_ready;
    assign cmd_dropped    = rst_n && rw_en && !w_ready;
    assign f2s_data_valid = (state_q == ST_BURST) && !rw_q;
    assign s2f_data_valid = (state_q == ST_BURST) && rw_q;

endmodule
`default_nettype wire
